// File: rtl/main_control_fsm_if.sv
// Control bundle between the multicycle control FSM and the datapath.
interface main_control_fsm_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       PCEn;
    logic       IorD;
    logic       Memwrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUsrcA;
    logic       PCsrc;
    logic [1:0] ALUsrcB;
    logic [2:0] ALUControl;
    logic       illegal;
    logic [3:0] state;

    // Controller side: reads instruction fields, drives strobes.
    modport master (
        input  opcode, funct, zero,
        output PCEn, IorD, Memwrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUsrcA, PCsrc,
        output ALUsrcB, ALUControl, illegal, state
    );

    // Datapath side.
    modport slave (
        output opcode, funct, zero,
        input  PCEn, IorD, Memwrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUsrcA, PCsrc,
        input  ALUsrcB, ALUControl, illegal, state
    );
endinterface

// File: rtl/main_control_fsm.sv
// Multicycle MIPS-style main control FSM (lw, sw, R-type, beq, addi).
// Strobes are registered alongside the state, so they are decoded from the next state.
module main_control_fsm #(
    parameter bit ADDI_EN      = 1'b1,
    parameter bit ILLEGAL_HOLD = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    main_control_fsm_if.master bus
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecute  = 4'd6,
        StAluWb    = 4'd7,
        StBranch   = 4'd8,
        StAddiExec = 4'd9,
        StAddiWb   = 4'd10,
        StHalt     = 4'd11
    } state_e;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic       pc_src;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
    } ctrl_t;

    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;
    localparam logic [5:0] OpR    = 6'b000000;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpAddi = 6'b001000;

    state_e     state_q, state_d;
    logic [5:0] funct_q, funct_d;
    ctrl_t      ctrl_q;
    logic       bad_instr;

    function automatic logic [2:0] alu_op(input logic [5:0] fn);
        case (fn)
            6'b100000: alu_op = 3'b010;
            6'b100010: alu_op = 3'b110;
            6'b100100: alu_op = 3'b000;
            6'b100101: alu_op = 3'b001;
            6'b101010: alu_op = 3'b111;
            default:   alu_op = 3'b010;
        endcase
    endfunction

    // Moore strobes for a state; BRANCH's PCEn is gated with zero at the output.
    function automatic ctrl_t decode(input state_e st, input logic [5:0] fn);
        ctrl_t c;
        c = '0;
        case (st)
            StFetch: begin
                c.ir_write = 1'b1; c.pc_en = 1'b1;
                c.alu_src_b = 2'b01; c.alu_control = 3'b010;
            end
            StDecode: begin
                c.alu_src_b = 2'b11; c.alu_control = 3'b010;
            end
            StMemAdr, StAddiExec: begin
                c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_control = 3'b010;
            end
            StMemRead:  c.iord = 1'b1;
            StMemWb:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            StMemWrite: begin c.iord = 1'b1; c.mem_write = 1'b1; end
            StExecute:  begin c.alu_src_a = 1'b1; c.alu_control = alu_op(fn); end
            StAluWb:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            StBranch: begin
                c.alu_src_a = 1'b1; c.alu_control = 3'b110; c.pc_src = 1'b1; c.pc_en = 1'b1;
            end
            StAddiWb:   c.reg_write = 1'b1;
            default:    c = '0;
        endcase
        return c;
    endfunction

    // Next-state logic and DECODE-time legality check.
    always_comb begin
        state_d   = StFetch;
        funct_d   = funct_q;
        bad_instr = 1'b0;
        case (state_q)
            StFetch:   state_d = StDecode;
            StDecode: begin
                funct_d = bus.funct;
                if (bus.opcode == OpLw || bus.opcode == OpSw) begin
                    state_d = StMemAdr;
                end else if (bus.opcode == OpR && (bus.funct == 6'b100000 ||
                             bus.funct == 6'b100010 || bus.funct == 6'b100100 ||
                             bus.funct == 6'b100101 || bus.funct == 6'b101010)) begin
                    state_d = StExecute;
                end else if (bus.opcode == OpBeq) begin
                    state_d = StBranch;
                end else if (ADDI_EN && bus.opcode == OpAddi) begin
                    state_d = StAddiExec;
                end else begin
                    bad_instr = 1'b1;
                    state_d   = ILLEGAL_HOLD ? StHalt : StFetch;
                end
            end
            StMemAdr:   state_d = (bus.opcode == OpSw) ? StMemWrite : StMemRead;
            StMemRead:  state_d = StMemWb;
            StExecute:  state_d = StAluWb;
            StAddiExec: state_d = StAddiWb;
            StHalt:     state_d = StHalt;
            default:    state_d = StFetch;
        endcase
    end

    // State, latched funct and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            funct_q <= '0;
            ctrl_q  <= decode(StFetch, 6'b000000);
        end else begin
            state_q <= state_d;
            funct_q <= funct_d;
            ctrl_q  <= decode(state_d, funct_d);
        end
    end

    // Everything is forced low while reset is held.
    assign bus.PCEn       = !rst && ctrl_q.pc_en && (state_q != StBranch || bus.zero);
    assign bus.IorD       = !rst && ctrl_q.iord;
    assign bus.Memwrite   = !rst && ctrl_q.mem_write;
    assign bus.IRWrite    = !rst && ctrl_q.ir_write;
    assign bus.RegDst     = !rst && ctrl_q.reg_dst;
    assign bus.MemtoReg   = !rst && ctrl_q.mem_to_reg;
    assign bus.RegWrite   = !rst && ctrl_q.reg_write;
    assign bus.ALUsrcA    = !rst && ctrl_q.alu_src_a;
    assign bus.PCsrc      = !rst && ctrl_q.pc_src;
    assign bus.ALUsrcB    = rst ? 2'b00 : ctrl_q.alu_src_b;
    assign bus.ALUControl = rst ? 3'b000 : ctrl_q.alu_control;
    assign bus.illegal    = !rst && bad_instr;
    assign bus.state      = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench: the driver pushes the expected outputs of each cycle, the monitor
// pops and compares them at the falling edge.
module tb_main_control_fsm;

    logic clk = 1'b0;
    logic rst0, rst1;
    always #5 clk = ~clk;

    main_control_fsm_if bus0 ();
    main_control_fsm_if bus1 ();

    main_control_fsm #(.ADDI_EN(1'b1), .ILLEGAL_HOLD(1'b0)) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (bus0.master)
    );

    main_control_fsm #(.ADDI_EN(1'b0), .ILLEGAL_HOLD(1'b1)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1.master)
    );

    // {PCEn,IorD,Memwrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUsrcA,PCsrc,ALUsrcB,ALUControl,illegal}
    localparam logic [14:0] VZero   = 15'b0;
    localparam logic [14:0] VFetch  = 15'b1_0_0_1_0_0_0_0_0_01_010_0;
    localparam logic [14:0] VDec    = 15'b0_0_0_0_0_0_0_0_0_11_010_0;
    localparam logic [14:0] VDecIll = 15'b0_0_0_0_0_0_0_0_0_11_010_1;
    localparam logic [14:0] VMemAdr = 15'b0_0_0_0_0_0_0_1_0_10_010_0;
    localparam logic [14:0] VMemRd  = 15'b0_1_0_0_0_0_0_0_0_00_000_0;
    localparam logic [14:0] VMemWb  = 15'b0_0_0_0_0_1_1_0_0_00_000_0;
    localparam logic [14:0] VMemWr  = 15'b0_1_1_0_0_0_0_0_0_00_000_0;
    localparam logic [14:0] VExSub  = 15'b0_0_0_0_0_0_0_1_0_00_110_0;
    localparam logic [14:0] VExOr   = 15'b0_0_0_0_0_0_0_1_0_00_001_0;
    localparam logic [14:0] VExSlt  = 15'b0_0_0_0_0_0_0_1_0_00_111_0;
    localparam logic [14:0] VAluWb  = 15'b0_0_0_0_1_0_1_0_0_00_000_0;
    localparam logic [14:0] VBrT    = 15'b1_0_0_0_0_0_0_1_1_00_110_0;
    localparam logic [14:0] VBrN    = 15'b0_0_0_0_0_0_0_1_1_00_110_0;
    localparam logic [14:0] VAddiEx = 15'b0_0_0_0_0_0_0_1_0_10_010_0;
    localparam logic [14:0] VAddiWb = 15'b0_0_0_0_0_0_1_0_0_00_000_0;

    typedef struct {
        logic [3:0]  st;
        logic [14:0] v;
        string       name;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   checks   = 0;
    int   failures = 0;

    logic [14:0] act0, act1;
    assign act0 = {bus0.PCEn, bus0.IorD, bus0.Memwrite, bus0.IRWrite, bus0.RegDst, bus0.MemtoReg,
                   bus0.RegWrite, bus0.ALUsrcA, bus0.PCsrc, bus0.ALUsrcB, bus0.ALUControl,
                   bus0.illegal};
    assign act1 = {bus1.PCEn, bus1.IorD, bus1.Memwrite, bus1.IRWrite, bus1.RegDst, bus1.MemtoReg,
                   bus1.RegWrite, bus1.ALUsrcA, bus1.PCsrc, bus1.ALUsrcB, bus1.ALUControl,
                   bus1.illegal};

    // Monitor: one expected entry per cycle per DUT.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            checks++;
            if (act0 !== e.v || bus0.state !== e.st || (bus0.Memwrite && bus0.RegWrite)) begin
                failures++;
                $display("FAIL %s dut0: got state=%0d ctrl=%b, want state=%0d ctrl=%b",
                         e.name, bus0.state, act0, e.st, e.v);
            end
        end
        if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            checks++;
            if (act1 !== e.v || bus1.state !== e.st) begin
                failures++;
                $display("FAIL %s dut1: got state=%0d ctrl=%b, want state=%0d ctrl=%b",
                         e.name, bus1.state, act1, e.st, e.v);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected during that cycle.
    task automatic step(input int d, input bit r, input logic [5:0] op, input logic [5:0] fn,
                        input bit z, input logic [3:0] es, input logic [14:0] ev,
                        input string nm);
        exp_t e;
        e.st = es; e.v = ev; e.name = nm;
        if (d == 0) begin
            rst0 = r; bus0.opcode = op; bus0.funct = fn; bus0.zero = z;
            exp_q0.push_back(e);
        end else begin
            rst1 = r; bus1.opcode = op; bus1.funct = fn; bus1.zero = z;
            exp_q1.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        bus0.opcode = '0; bus0.funct = '0; bus0.zero = 1'b0;
        bus1.opcode = '0; bus1.funct = '0; bus1.zero = 1'b0;
        @(posedge clk);
        #1;

        // dut0: default parameters
        step(0, 1, 6'b100011, 6'b0, 0, 4'd0, VZero,   "reset");
        step(0, 0, 6'b100011, 6'b0, 0, 4'd0, VFetch,  "lw_fetch");
        step(0, 0, 6'b100011, 6'b0, 0, 4'd1, VDec,    "lw_decode");
        step(0, 0, 6'b100011, 6'b0, 0, 4'd2, VMemAdr, "lw_memadr");
        step(0, 0, 6'b100011, 6'b0, 0, 4'd3, VMemRd,  "lw_memread");
        step(0, 0, 6'b100011, 6'b0, 0, 4'd4, VMemWb,  "lw_memwb");
        step(0, 0, 6'b101011, 6'b0, 0, 4'd0, VFetch,  "sw_fetch");
        step(0, 0, 6'b101011, 6'b0, 0, 4'd1, VDec,    "sw_decode");
        step(0, 0, 6'b101011, 6'b0, 0, 4'd2, VMemAdr, "sw_memadr");
        step(0, 0, 6'b101011, 6'b0, 0, 4'd5, VMemWr,  "sw_memwrite");
        step(0, 0, 6'b000000, 6'b100010, 0, 4'd0, VFetch, "sub_fetch");
        step(0, 0, 6'b000000, 6'b100010, 0, 4'd1, VDec,   "sub_decode");
        step(0, 0, 6'b000000, 6'b100000, 0, 4'd6, VExSub, "sub_exec_latched");
        step(0, 0, 6'b000000, 6'b100000, 0, 4'd7, VAluWb, "sub_aluwb");
        step(0, 0, 6'b000000, 6'b100101, 0, 4'd0, VFetch, "or_fetch");
        step(0, 0, 6'b000000, 6'b100101, 0, 4'd1, VDec,   "or_decode");
        step(0, 0, 6'b000000, 6'b100101, 0, 4'd6, VExOr,  "or_exec");
        step(0, 0, 6'b000000, 6'b100101, 0, 4'd7, VAluWb, "or_aluwb");
        step(0, 0, 6'b000000, 6'b101010, 0, 4'd0, VFetch, "slt_fetch");
        step(0, 0, 6'b000000, 6'b101010, 0, 4'd1, VDec,   "slt_decode");
        step(0, 0, 6'b000000, 6'b101010, 0, 4'd6, VExSlt, "slt_exec");
        step(0, 0, 6'b000000, 6'b101010, 0, 4'd7, VAluWb, "slt_aluwb");
        step(0, 0, 6'b000100, 6'b0, 1, 4'd0, VFetch,  "beqt_fetch");
        step(0, 0, 6'b000100, 6'b0, 1, 4'd1, VDec,    "beqt_decode");
        step(0, 0, 6'b000100, 6'b0, 1, 4'd8, VBrT,    "beqt_branch");
        step(0, 0, 6'b000100, 6'b0, 0, 4'd0, VFetch,  "beqn_fetch");
        step(0, 0, 6'b000100, 6'b0, 0, 4'd1, VDec,    "beqn_decode");
        step(0, 0, 6'b000100, 6'b0, 0, 4'd8, VBrN,    "beqn_branch");
        step(0, 0, 6'b001000, 6'b0, 0, 4'd0, VFetch,  "addi_fetch");
        step(0, 0, 6'b001000, 6'b0, 0, 4'd1, VDec,    "addi_decode");
        step(0, 0, 6'b001000, 6'b0, 0, 4'd9, VAddiEx, "addi_exec");
        step(0, 0, 6'b001000, 6'b0, 0, 4'd10, VAddiWb, "addi_wb");
        step(0, 0, 6'b111111, 6'b0, 0, 4'd0, VFetch,  "ill_fetch");
        step(0, 0, 6'b111111, 6'b0, 0, 4'd1, VDecIll, "ill_decode");
        step(0, 0, 6'b000000, 6'b000001, 0, 4'd0, VFetch,  "ill_back_fetch");
        step(0, 0, 6'b000000, 6'b000001, 0, 4'd1, VDecIll, "badfunct_decode");
        step(0, 0, 6'b100011, 6'b0, 0, 4'd0, VFetch,  "rlw_fetch");
        step(0, 0, 6'b100011, 6'b0, 0, 4'd1, VDec,    "rlw_decode");
        step(0, 0, 6'b100011, 6'b0, 0, 4'd2, VMemAdr, "rlw_memadr");
        step(0, 1, 6'b100011, 6'b0, 0, 4'd0, VZero,   "rst_in_memread");
        step(0, 0, 6'b100011, 6'b0, 0, 4'd0, VFetch,  "after_rst_fetch");
        step(0, 0, 6'b100011, 6'b0, 0, 4'd1, VDec,    "after_rst_decode");

        // dut1: addi disabled, illegal parks in HALT
        step(1, 1, 6'b001000, 6'b0, 0, 4'd0,  VZero,   "h_reset");
        step(1, 0, 6'b001000, 6'b0, 0, 4'd0,  VFetch,  "h_fetch");
        step(1, 0, 6'b001000, 6'b0, 0, 4'd1,  VDecIll, "h_addi_illegal");
        step(1, 0, 6'b100011, 6'b0, 1, 4'd11, VZero,   "h_halt0");
        step(1, 0, 6'b100011, 6'b0, 1, 4'd11, VZero,   "h_halt1");
        step(1, 0, 6'b000100, 6'b0, 1, 4'd11, VZero,   "h_halt2");
        step(1, 1, 6'b100011, 6'b0, 0, 4'd0,  VZero,   "h_rst");
        step(1, 0, 6'b100011, 6'b0, 0, 4'd0,  VFetch,  "h_after_rst_fetch");
        step(1, 0, 6'b100011, 6'b0, 0, 4'd1,  VDec,    "h_after_rst_decode");

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d, want 0", exp_q0.size() + exp_q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/main_control_fsm.md
MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 SHALL have parameter ADDI_EN, default 1, meaning addi is decoded as legal; when 0, addi is treated as illegal.
REQ-002 SHALL have parameter ILLEGAL_HOLD, default 0, meaning: 0 returns to FETCH after an illegal instruction; 1 parks in HALT until reset.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 opcode  in  6  instr[31:26] from the datapath instruction register.
REQ-006 funct  in  6  instr[5:0] from the datapath instruction register.
REQ-007 zero  in  1  ALU zero flag from the datapath.
REQ-008 PCEn, IorD, Memwrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUsrcA, PCsrc  out  1 each  datapath strobes and mux selects, bit-exact to the dataPath inputs of the same names.
REQ-009 ALUsrcB  out  2  00=reg B, 01=constant 4, 10=sign-extended imm, 11=sign-extended imm<<2.
REQ-010 ALUControl  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt.
REQ-011 illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode or funct.
REQ-012 state  out  4  current state encoding, for debug.

Function
REQ-013 SHALL use states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, HALT=11.
REQ-014 Outputs SHALL be Moore, decoded from state, except PCEn in BRANCH, which depends on zero. Every output not listed for a state SHALL be 0.
REQ-015 FETCH: IorD=0, IRWrite=1, PCEn=1, ALUsrcA=0, ALUsrcB=01, ALUControl=010, PCsrc=0; next state is DECODE.
REQ-016 DECODE: ALUsrcA=0, ALUsrcB=11, ALUControl=010.
REQ-017 DECODE SHALL latch funct into an internal register; EXECUTE SHALL use only the latched value.
REQ-018 DECODE next state by opcode: 100011 or 101011 -> MEMADR; 000000 with funct in {100000,100010,100100,100101,101010} -> EXECUTE; 000100 -> BRANCH; 001000 (with ADDI_EN=1) -> ADDIEXEC.
REQ-019 Any other opcode/funct in DECODE SHALL assert illegal and go to FETCH, or to HALT when ILLEGAL_HOLD=1.
REQ-020 MEMADR: ALUsrcA=1, ALUsrcB=10, ALUControl=010; next state is MEMREAD for lw, MEMWRITE for sw.
REQ-021 MEMREAD: IorD=1; next state is MEMWB.
REQ-022 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; next state is FETCH.
REQ-023 MEMWRITE: IorD=1, Memwrite=1; next state is FETCH.
REQ-024 EXECUTE: ALUsrcA=1, ALUsrcB=00; ALUControl from latched funct (add 010, sub 110, and 000, or 001, slt 111); next state is ALUWB.
REQ-025 ALUWB: RegWrite=1, RegDst=1, MemtoReg=0; next state is FETCH.
REQ-026 BRANCH: ALUsrcA=1, ALUsrcB=00, ALUControl=110, PCsrc=1, PCEn=zero; next state is FETCH.
REQ-027 ADDIEXEC: ALUsrcA=1, ALUsrcB=10, ALUControl=010; next state is ADDIWB.
REQ-028 ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; next state is FETCH.
REQ-029 HALT: all strobes 0; SHALL remain in HALT until rst.
REQ-030 Latency in cycles, FETCH through last state inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3.
REQ-031 Unused encodings 12-15 SHALL go to FETCH on the next edge with all outputs 0.
REQ-032 Memwrite and RegWrite SHALL never be 1 in the same cycle.

Reset
REQ-033 When rst=1 at a rising edge, state SHALL become FETCH and the latched funct SHALL become 000000, regardless of current state, including mid-instruction and HALT.
REQ-034 While rst=1, all outputs, including illegal and PCEn, SHALL be forced to 0.
REQ-035 state SHALL read 0 in the cycle after rst deasserts, and FETCH strobes SHALL be active in that cycle.

Verification
REQ-036 Reset, then opcode=100011: states 0,1,2,3,4,0. Cycle 3: ALUsrcA=1, ALUsrcB=10, ALUControl=010. Cycle 4: IorD=1. Cycle 5: RegWrite=1, MemtoReg=1, RegDst=0.
REQ-037 opcode=101011: states 0,1,2,5,0. State 5: Memwrite=1, IorD=1, RegWrite=0.
REQ-038 opcode=000000 with funct=100010, funct input changed to 100000 after DECODE: EXECUTE drives ALUControl=110; ALUWB drives RegDst=1, RegWrite=1.
REQ-039 opcode=000100: zero=1 gives PCEn=1, PCsrc=1 in BRANCH; zero=0 gives PCEn=0. Next state is FETCH in both cases.
REQ-040 opcode=111111: illegal=1 for exactly one cycle in DECODE, then state 0; with ILLEGAL_HOLD=1, state stays 11 until rst.
REQ-041 rst pulsed in MEMREAD: outputs are 0 during that cycle, state is 0 on the next edge, and no MEMWB write occurs.
